ram_writer: RTL
===============

Name: ram_writer

Overview:
- Write-side controller and storage for the small lookup RAM: accepts single writes or fixed-length bursts over a valid/ready handshake and stores them in an internal DEPTH x DW register array.
- Exposes an asynchronous read port so existing combinational readers (2-bit address in, 2-bit data out) can consume the programmed contents.
- Sits between a configuration source (testbench or sequencer) and the address-decoding read logic.

Parameters:
- AW, 2, address width in bits.
- DEPTH, 4, number of entries; fixed at 2**AW.
- DW, 2, data width per entry in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  source presents a write beat.
- wr_ready  output  1  block can accept a beat this cycle.
- wr_burst  input  1  sampled only on the first accepted beat; 1 = DEPTH-beat burst.
- wr_addr  input  AW  write address; used only on the first beat.
- wr_data  input  DW  write data for the current beat.
- busy  output  1  high in the BURST and DONE states.
- done  output  1  one-cycle pulse after a single write or burst completes.
- rd_addr  input  AW  read address.
- rd_data  output  DW  combinational read of mem[rd_addr].

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, all mem entries=0, address counter=0, beat counter=0.
  - wr_ready=1, busy=0, done=0 in the cycle following reset.
- Handshake: a beat transfers on a rising edge where wr_valid&&wr_ready. The source holds wr_data stable until the transfer.
- States:
  - IDLE: wr_ready=1.
    - Transfer with wr_burst=0: mem[wr_addr]<=wr_data; next=DONE.
    - Transfer with wr_burst=1: mem[wr_addr]<=wr_data; addr_ctr<=wr_addr+1 (mod DEPTH); beat_ctr<=1; next=BURST.
  - BURST: wr_ready=1; wr_addr is ignored.
    - Each transfer: mem[addr_ctr]<=wr_data; addr_ctr increments mod DEPTH (wraps DEPTH-1 -> 0); beat_ctr increments.
    - When the transfer is beat number DEPTH: next=DONE.
    - wr_valid=0 stalls without a timeout; counters hold.
  - DONE: wr_ready=0, done=1 for exactly one cycle; next=IDLE unconditionally.
- Latency:
  - Single write: data is visible on rd_data the cycle after the accepting edge; done is high in that same cycle; wr_ready returns to 1 one cycle later.
  - Burst of DEPTH beats with wr_valid held high: DEPTH accept cycles + 1 DONE cycle.
- Read/write collision (rd_addr == write target in the accept cycle): rd_data shows the old value until the edge, then the new value.
- Reset asserted mid-burst: burst aborts; all mem entries return to 0; no done pulse.
- wr_burst and wr_addr changes during BURST have no effect.
- Arithmetic: counters are AW bits wide, except beat_ctr, which is AW+1 bits so it can reach DEPTH.

Optional Feature:
- Macro: RAM_WRITER_STATS_EN.
- Defined:
  - Adds output port wr_count [7:0], the count of accepted beats (single and burst).
  - Cleared by rst; saturates at 255; increments on every transfer edge.
- Undefined: the wr_count port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, rst=0 -> wr_ready=1, busy=0, done=0; rd_data=0 for rd_addr=0..3.
- Single write: valid=1, burst=0, addr=2, data=2'b11 for one cycle.
  - Next cycle: done=1, wr_ready=0; rd_addr=2 gives rd_data=2'b11.
  - The following cycle: wr_ready=1; entries 0, 1, 3 still read 0.
- Burst with wrap: burst=1, start addr=3, data 01,10,11,00 on consecutive cycles with valid high.
  - mem[3]=01, mem[0]=10, mem[1]=11, mem[2]=00.
  - busy=1 from the second beat through DONE; a single done pulse 4 cycles after the first beat is accepted.
- Stall mid-burst: burst starting at addr=0; drop valid for 3 cycles after beat 2.
  - Counters hold and no write occurs during the stall.
  - After resuming, beats 3 and 4 land at addr 2 and 3; done pulses once.
- Reset mid-burst: assert rst after beat 2 of a burst -> all entries read 0, state IDLE, no done pulse.
- STATS (RAM_WRITER_STATS_EN defined): 1 single write + 1 burst -> wr_count=5; 300 single writes from reset -> wr_count=255.

Source files
------------

// File: rtl/ram_writer_if.sv
// Write-side bus for ram_writer: valid/ready handshake carrying burst flag, address and data.
interface ram_writer_if #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 2
);
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_burst;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (output wr_valid, wr_burst, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_burst, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/ram_writer.sv
// ram_writer: write controller plus DEPTH x DW register array with a combinational read port.
// Single writes or DEPTH-beat wrapping bursts are accepted over a valid/ready handshake.
// Optional macro RAM_WRITER_STATS_EN adds o_wr_count, a saturating count of accepted beats.
module ram_writer #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ram_writer_if.slave   wr_if,
    output logic          o_busy,
    output logic          o_done,
`ifdef RAM_WRITER_STATS_EN
    output logic [7:0]    o_wr_count,
`endif
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data_c
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned BW    = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic          w_ready_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_addr_ctr;
    logic [BW-1:0] r_beat_ctr;
    logic          w_xfer;
    logic          w_last_beat;
    logic [AW-1:0] w_wr_addr;

    assign w_xfer         = wr_if.wr_valid && r_ready;
    assign w_last_beat    = (r_beat_ctr == BW'(DEPTH - 1));
    assign w_wr_addr      = (r_state == S_BURST) ? r_addr_ctr : wr_if.wr_addr;
    assign wr_if.wr_ready = r_ready;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_rd_data_c    = r_mem[i_rd_addr];

    // State register; handshake/status outputs are registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state decode: the burst ends on the transfer that is beat number DEPTH.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = wr_if.wr_burst ? S_BURST : S_DONE;
                end
            end
            S_BURST: begin
                if (w_xfer && w_last_beat) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the state being entered.
    always_comb begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            S_BURST: w_busy_nxt = 1'b1;
            S_DONE: begin
                w_ready_nxt = 1'b0;
                w_busy_nxt  = 1'b1;
                w_done_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    // Storage array and burst address/beat counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_addr_ctr <= '0;
            r_beat_ctr <= '0;
        end else if (w_xfer) begin
            r_mem[w_wr_addr] <= wr_if.wr_data;
            if (r_state == S_IDLE) begin
                if (wr_if.wr_burst) begin
                    r_addr_ctr <= AW'(wr_if.wr_addr + 1'b1);
                    r_beat_ctr <= BW'(1);
                end
            end else begin
                r_addr_ctr <= AW'(r_addr_ctr + 1'b1);
                r_beat_ctr <= BW'(r_beat_ctr + 1'b1);
            end
        end
    end

`ifdef RAM_WRITER_STATS_EN
    logic [7:0] r_wr_count;

    assign o_wr_count = r_wr_count;

    // Saturating count of accepted beats.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_count <= 8'd0;
        end else if (w_xfer && (r_wr_count != 8'hFF)) begin
            r_wr_count <= 8'(r_wr_count + 1'b1);
        end
    end
`endif
endmodule
